cmd_loader: RTL

//  Fetches the compressed command table from SDRAM over one MIG read port and pushes it into the command FIFO

---
 rtl/fusion_defs.sv | 15 +
 rtl/cmd_loader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fusion_defs.sv
// Shared definitions for the command-table loader: MIG instruction codes,
// command geometry and loader state encodings.
package fusion_defs;

  localparam logic [2:0] MIG_INSTR_RD = 3'b001;
  localparam int         CMD_WORDS    = 6;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_ISSUE = 2'd1,
    LD_DRAIN = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/cmd_loader.sv
// Loads cmd_size*WORDS_PER_CMD words from SDRAM via one MIG read port into the command FIFO.
// Optional CMD_LOADER_CHECKSUM_EN adds a running 32-bit sum of every word written.
module cmd_loader
  import fusion_defs::*;
#(
  parameter logic [29:0] CMD_BASE_ADDR = 30'h000_0000,
  parameter int          BURST_MAX     = 32,
  parameter int          WORDS_PER_CMD = CMD_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  cmd_size,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_rd_en,
  input  logic [31:0] p_rd_data,
  input  logic        p_rd_empty,
  output logic [31:0] cmd_fifo_din,
  output logic        cmd_fifo_wr_en,
  input  logic        cmd_fifo_full,
  output logic        busy,
  output logic        done,
  output logic [9:0]  words_loaded
`ifdef CMD_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [9:0] BURST_MAX_W = 10'(BURST_MAX);
  localparam logic [9:0] WPC_W       = 10'(WORDS_PER_CMD);

  ld_state_t   state_reg, state_next;
  logic [9:0]  total_reg, total_next;
  logic [9:0]  issued_reg, issued_next;
  logic [9:0]  words_loaded_reg, words_loaded_next;
  logic [29:0] addr_reg, addr_next;
  logic [6:0]  burst_len_reg, burst_len_next;
  logic [6:0]  burst_cnt_reg, burst_cnt_next;

  logic [9:0]  total_load;
  logic [9:0]  remaining_issue;
  logic [6:0]  len;
  logic        xfer;

  assign total_load      = 10'(cmd_size) * WPC_W;
  assign remaining_issue = total_reg - issued_reg;
  assign len             = (remaining_issue > BURST_MAX_W) ? BURST_MAX_W[6:0] : remaining_issue[6:0];

  // Read data passes straight through; withholding the pop keeps p_rd_data valid during a stall.
  assign xfer           = (state_reg == LD_DRAIN) & ~p_rd_empty & ~cmd_fifo_full;
  assign p_rd_en        = xfer;
  assign cmd_fifo_wr_en = xfer;
  assign cmd_fifo_din   = p_rd_data;

  assign p_cmd_en        = (state_reg == LD_ISSUE) & ~p_cmd_full;
  assign p_cmd_instr     = MIG_INSTR_RD;
  assign p_cmd_bl        = (state_reg == LD_ISSUE) ? 6'(len - 7'd1) : 6'd0;
  assign p_cmd_byte_addr = addr_reg;
  assign busy            = (state_reg == LD_ISSUE) | (state_reg == LD_DRAIN);
  assign done            = (state_reg == LD_DONE);
  assign words_loaded    = words_loaded_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= LD_IDLE;
      total_reg        <= '0;
      issued_reg       <= '0;
      words_loaded_reg <= '0;
      addr_reg         <= CMD_BASE_ADDR;
      burst_len_reg    <= '0;
      burst_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      total_reg        <= total_next;
      issued_reg       <= issued_next;
      words_loaded_reg <= words_loaded_next;
      addr_reg         <= addr_next;
      burst_len_reg    <= burst_len_next;
      burst_cnt_reg    <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    total_next        = total_reg;
    issued_next       = issued_reg;
    words_loaded_next = words_loaded_reg;
    addr_next         = addr_reg;
    burst_len_next    = burst_len_reg;
    burst_cnt_next    = burst_cnt_reg;
    case (state_reg)
      LD_IDLE: begin
        if (start) begin
          total_next        = total_load;
          issued_next       = '0;
          words_loaded_next = '0;
          burst_cnt_next    = '0;
          addr_next         = CMD_BASE_ADDR;
          state_next        = (cmd_size != 7'd0) ? LD_ISSUE : LD_DONE;
        end
      end
      LD_ISSUE: begin
        if (!p_cmd_full) begin
          burst_len_next = len;
          issued_next    = issued_reg + 10'(len);
          addr_next      = addr_reg + (30'(len) << 2);
          state_next     = LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        if (xfer) begin
          words_loaded_next = words_loaded_reg + 10'd1;
          if (burst_cnt_reg + 7'd1 == burst_len_reg) begin
            burst_cnt_next = '0;
            state_next     = (issued_reg != total_reg) ? LD_ISSUE : LD_DONE;
          end else begin
            burst_cnt_next = burst_cnt_reg + 7'd1;
          end
        end
      end
      LD_DONE: begin
        if (!start) state_next = LD_IDLE;
      end
      default: state_next = LD_IDLE;
    endcase
  end

`ifdef CMD_LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg, checksum_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum_reg <= '0;
    else     checksum_reg <= checksum_next;
  end

  always_comb begin
    checksum_next = checksum_reg;
    if (state_reg == LD_IDLE && start) checksum_next = '0;
    else if (xfer)                     checksum_next = checksum_reg + p_rd_data;
  end

  assign checksum = checksum_reg;
`endif

endmodule
